// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline buffer controllers: FSM states, the
// buffer-control bundle and the canned control patterns used by the hazard unit.
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } ctrl_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_write;
    logic idex_bubble;
  } buf_ctrl_t;

  localparam buf_ctrl_t CTRL_RUN = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                                     idex_write: 1'b1, idex_bubble: 1'b0};
  localparam buf_ctrl_t CTRL_FLUSH = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1,
                                       idex_write: 1'b1, idex_bubble: 1'b1};
  localparam buf_ctrl_t CTRL_STALL = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                       idex_write: 1'b1, idex_bubble: 1'b1};
  localparam buf_ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                        idex_write: 1'b0, idex_bubble: 1'b0};
  localparam buf_ctrl_t CTRL_RESET = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1,
                                       idex_write: 1'b1, idex_bubble: 1'b1};

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-unit bundle: ID/EX hazard sources from the datapath and the
// buffer write/flush/bubble controls returned by the controller.
interface pipeline_hazard_ctrl_if #(
  parameter int REG_W = 5
);
  logic [REG_W-1:0] id_rs;
  logic [REG_W-1:0] id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic [REG_W-1:0] ex_rt;
  logic             ex_mem_read;
  logic             ex_branch_taken;
  logic             ex_mdu_start;

  logic pc_write;
  logic ifid_write;
  logic ifid_flush;
  logic idex_write;
  logic idex_bubble;
  logic mdu_busy;

  modport master (
    output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rt, ex_mem_read,
           ex_branch_taken, ex_mdu_start,
    input  pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, mdu_busy
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_rt, ex_mem_read,
           ex_branch_taken, ex_mdu_start,
    output pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, mdu_busy
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Combinational load-use detector: flags an ID instruction reading the
// register a load in EX is about to write; $0 never counts as a dependence.
module load_use_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             ex_mem_read,
  output logic             hazard
);

  logic ex_rt_live;
  logic rs_dep;
  logic rt_dep;

  assign ex_rt_live = (ex_rt != REG_W'(REG_ZERO));
  assign rs_dep     = id_uses_rs && (id_rs == ex_rt);
  assign rt_dep     = id_uses_rt && (id_rt == ex_rt);
  assign hazard     = ex_mem_read && ex_rt_live && (rs_dep || rt_dep);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: drives PC, IF/ID and ID/EX load/flush/bubble
// controls. Optional HAZARD_PERF_EN adds stall and flush performance counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MDU_LATENCY = 4,
  parameter int REG_W       = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]           perf_stall_cycles,
  output logic [31:0]           perf_flushes
`endif
);

  localparam int CNT_W = $clog2(MDU_LATENCY);
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(MDU_LATENCY - 2);

  ctrl_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  buf_ctrl_t        ctrl;
  logic             busy;
  logic             load_use;

  load_use_detect #(.REG_W(REG_W)) u_load_use (
    .id_rs      (hz.id_rs),
    .id_rt      (hz.id_rt),
    .id_uses_rs (hz.id_uses_rs),
    .id_uses_rt (hz.id_uses_rt),
    .ex_rt      (hz.ex_rt),
    .ex_mem_read(hz.ex_mem_read),
    .hazard     (load_use)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The mult/div start cycle already freezes the front end, so MDU_WAIT only
  // covers the remaining MDU_LATENCY-2 cycles and is skipped when that is zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl    = CTRL_RUN;
    busy    = 1'b0;
    if (rst) begin
      ctrl = CTRL_RESET;
    end else begin
      unique case (state_q)
        RUN: begin
          if (hz.ex_branch_taken) begin
            ctrl = CTRL_FLUSH;
          end else if (hz.ex_mdu_start) begin
            ctrl = CTRL_FREEZE;
            if (MDU_LATENCY > 2) begin
              state_d = MDU_WAIT;
              cnt_d   = CNT_START;
            end
          end else if (load_use) begin
            ctrl = CTRL_STALL;
          end
        end
        MDU_WAIT: begin
          ctrl  = CTRL_FREEZE;
          busy  = 1'b1;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q <= CNT_W'(1)) begin
            state_d = RUN;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign hz.pc_write    = ctrl.pc_write;
  assign hz.ifid_write  = ctrl.ifid_write;
  assign hz.ifid_flush  = ctrl.ifid_flush;
  assign hz.idex_write  = ctrl.idex_write;
  assign hz.idex_bubble = ctrl.idex_bubble;
  assign hz.mdu_busy    = busy;

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_flushes      <= '0;
    end else begin
      if (!ctrl.pc_write) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (ctrl.ifid_flush) perf_flushes <= perf_flushes + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: a reference model pushes expected
// controls per driven cycle; a negedge monitor pops and compares them.
module tb_pipeline_hazard_ctrl;

  localparam int MDU_LAT = 4;

  typedef struct {
    string       tag;
    logic [5:0]  outs;
    logic        chk_perf;
    logic [31:0] stalls;
    logic [31:0] flushes;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  exp_t sb[$];

  int          m_wait = 0;
  logic [31:0] m_stalls = '0;
  logic [31:0] m_flushes = '0;

  pipeline_hazard_ctrl_if #(.REG_W(5)) hz();

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [31:0] perf_flushes;
`endif

  pipeline_hazard_ctrl #(.MDU_LATENCY(MDU_LAT), .REG_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz)
`ifdef HAZARD_PERF_EN
    ,
    .perf_stall_cycles(perf_stall_cycles),
    .perf_flushes     (perf_flushes)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Outputs packed as {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, mdu_busy}.
  task automatic applyStimulus(input string tag, input logic r,
                               input logic [4:0] rs, input logic [4:0] rt,
                               input logic urs, input logic urt,
                               input logic [4:0] exrt, input logic memrd,
                               input logic br, input logic mdu);
    exp_t e;
    logic lu;
    @(posedge clk);
    #1;
    rst                = r;
    hz.id_rs           = rs;
    hz.id_rt           = rt;
    hz.id_uses_rs      = urs;
    hz.id_uses_rt      = urt;
    hz.ex_rt           = exrt;
    hz.ex_mem_read     = memrd;
    hz.ex_branch_taken = br;
    hz.ex_mdu_start    = mdu;

    lu = memrd && (exrt != 5'd0) && ((urs && rs == exrt) || (urt && rt == exrt));
    e.tag      = tag;
    e.chk_perf = !r;
    e.stalls   = m_stalls;
    e.flushes  = m_flushes;
    if (r) begin
      e.outs = 6'b001110;
      m_wait = 0;
    end else if (m_wait > 0) begin
      e.outs = 6'b000001;
      m_wait--;
    end else if (br) begin
      e.outs = 6'b111110;
    end else if (mdu) begin
      e.outs = 6'b000000;
      m_wait = MDU_LAT - 2;
    end else if (lu) begin
      e.outs = 6'b000110;
    end else begin
      e.outs = 6'b110100;
    end

    if (r) begin
      m_stalls  = '0;
      m_flushes = '0;
    end else begin
      if (!e.outs[5]) m_stalls++;
      if (e.outs[3]) m_flushes++;
    end
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checkOutput(e.tag, {26'd0, hz.pc_write, hz.ifid_write, hz.ifid_flush,
                          hz.idex_write, hz.idex_bubble, hz.mdu_busy}, {26'd0, e.outs});
`ifdef HAZARD_PERF_EN
      if (e.chk_perf) begin
        checkOutput({e.tag, "_stalls"}, perf_stall_cycles, e.stalls);
        checkOutput({e.tag, "_flushes"}, perf_flushes, e.flushes);
      end
`endif
    end
  end

  initial begin
    hz.id_rs = '0; hz.id_rt = '0; hz.id_uses_rs = 1'b0; hz.id_uses_rt = 1'b0;
    hz.ex_rt = '0; hz.ex_mem_read = 1'b0; hz.ex_branch_taken = 1'b0; hz.ex_mdu_start = 1'b0;

    //            tag            rst rs     rt     urs   urt   exrt   mrd   br    mdu
    applyStimulus("reset0",      1, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0);
    applyStimulus("reset1",      1, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0);
    applyStimulus("idle",        0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0);
    applyStimulus("lu_rs",       0, 5'd8,  5'd3,  1'b1, 1'b1, 5'd8,  1'b1, 1'b0, 1'b0);
    applyStimulus("lu_clear",    0, 5'd8,  5'd3,  1'b1, 1'b1, 5'd8,  1'b0, 1'b0, 1'b0);
    applyStimulus("lu_rt",       0, 5'd4,  5'd9,  1'b1, 1'b1, 5'd9,  1'b1, 1'b0, 1'b0);
    applyStimulus("lu_rt_unused",0, 5'd4,  5'd9,  1'b1, 1'b0, 5'd9,  1'b1, 1'b0, 1'b0);
    applyStimulus("lu_rs_unused",0, 5'd8,  5'd3,  1'b0, 1'b1, 5'd8,  1'b1, 1'b0, 1'b0);
    applyStimulus("zero_reg",    0, 5'd0,  5'd0,  1'b1, 1'b1, 5'd0,  1'b1, 1'b0, 1'b0);
    applyStimulus("b2b_ld1",     0, 5'd5,  5'd0,  1'b1, 1'b0, 5'd5,  1'b1, 1'b0, 1'b0);
    applyStimulus("b2b_ld2",     0, 5'd6,  5'd0,  1'b1, 1'b0, 5'd6,  1'b1, 1'b0, 1'b0);
    applyStimulus("branch",      0, 5'd8,  5'd3,  1'b1, 1'b0, 5'd8,  1'b1, 1'b1, 1'b0);
    applyStimulus("post_branch", 0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0);
    applyStimulus("mdu_start",   0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1);
    applyStimulus("mdu_wait1",   0, 5'd8,  5'd3,  1'b1, 1'b0, 5'd8,  1'b1, 1'b1, 1'b1);
    applyStimulus("mdu_wait2",   0, 5'd8,  5'd3,  1'b1, 1'b0, 5'd8,  1'b1, 1'b0, 1'b1);
    applyStimulus("mdu_done_lu", 0, 5'd8,  5'd3,  1'b1, 1'b0, 5'd8,  1'b1, 1'b0, 1'b0);
    applyStimulus("mdu_done",    0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0);
    applyStimulus("br_and_mdu",  0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b1);
    applyStimulus("br_mdu_after",0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0);
    applyStimulus("rst_mdu_st",  0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1);
    applyStimulus("rst_mdu_w1",  0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0);
    applyStimulus("rst_mdu_w2",  1, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0);
    applyStimulus("rst_release", 0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0);
    applyStimulus("perf_lu",     0, 5'd7,  5'd0,  1'b1, 1'b0, 5'd7,  1'b1, 1'b0, 1'b0);
    applyStimulus("perf_after",  0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      applyStimulus("random",
                    ($urandom_range(0, 49) == 0),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
    end

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
